// File: rtl/bp_trace_pkg.sv
// Shared types for the breakpoint trace collector: FSM state, hit record and wildcard.
package bp_trace_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } bp_state_t;

    // Record fields are sized for the largest supported configuration; the top trims them.
    localparam int MAX_IDX_W = 8;
    localparam int MAX_TS_W  = 64;

    localparam logic [31:0] BP_WILDCARD = 32'hFFFFFFFF;

    typedef struct packed {
        logic [31:0]          instance_id;
        logic [31:0]          stmt_id;
        logic [MAX_IDX_W-1:0] bp_idx;
        logic [MAX_TS_W-1:0]  timestamp;
    } hit_rec_t;

    function automatic logic stmt_match(input logic [31:0] entry_stmt, input logic [31:0] ev_stmt);
        return (entry_stmt == BP_WILDCARD) || (entry_stmt == ev_stmt);
    endfunction

endpackage

// File: rtl/bp_hit_fifo.sv
// Show-ahead FIFO for hit records; accepts a push while full when a pop happens in the same cycle.
module bp_hit_fifo
    import bp_trace_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = hit_rec_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     wr_data,
    input  logic pop,
    output T     rd_data,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    T             mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_pop;
    logic         do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is forced to zero when empty so stale storage never leaks onto the outputs.
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/bp_trace_collector.sv
// Matches trace events against a breakpoint table, queues hit records and raises a halt request.
module bp_trace_collector
    import bp_trace_pkg::*;
#(
    parameter int NUM_BP     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_WIDTH   = 32,
    localparam int IDX_W     = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                trace_valid,
    input  logic [31:0]         trace_instance_id,
    input  logic [31:0]         trace_stmt_id,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic                cfg_en,
    input  logic                cfg_halt,
    input  logic [31:0]         cfg_instance_id,
    input  logic [31:0]         cfg_stmt_id,
    output logic                hit_valid,
    input  logic                hit_ready,
    output logic [31:0]         hit_instance_id,
    output logic [31:0]         hit_stmt_id,
    output logic [IDX_W-1:0]    hit_bp_idx,
    output logic [TS_WIDTH-1:0] hit_timestamp,
    input  logic                resume,
    output logic                halted,
    output logic [15:0]         overflow_count
);

    logic [NUM_BP-1:0]   bp_en;
    logic [NUM_BP-1:0]   bp_halt;
    logic [31:0]         bp_inst [NUM_BP];
    logic [31:0]         bp_stmt [NUM_BP];

    logic [TS_WIDTH-1:0] ts_count;
    bp_state_t           state;
    bp_state_t           next_state;

    logic                any_match;
    logic [IDX_W-1:0]    win_idx;
    logic                accept;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    hit_rec_t            push_rec;
    hit_rec_t            head;
    logic                unused_head_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_en   <= '0;
            bp_halt <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_inst[i] <= '0;
                bp_stmt[i] <= '0;
            end
        end else if (cfg_we && (int'(cfg_idx) < NUM_BP)) begin
            bp_en[cfg_idx]   <= cfg_en;
            bp_halt[cfg_idx] <= cfg_halt;
            bp_inst[cfg_idx] <= cfg_instance_id;
            bp_stmt[cfg_idx] <= cfg_stmt_id;
        end
    end

    // Scan from the top down so the lowest matching entry is the one left standing.
    always_comb begin
        any_match = 1'b0;
        win_idx   = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_en[i] && (bp_inst[i] == trace_instance_id) &&
                stmt_match(bp_stmt[i], trace_stmt_id)) begin
                any_match = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
    end

    assign accept = trace_valid && (state == RUN) && any_match;
    assign pop    = hit_valid && hit_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_count <= '0;
        end else begin
            ts_count <= ts_count + TS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_count <= '0;
        end else if (accept && fifo_full && !pop && (overflow_count != 16'hFFFF)) begin
            overflow_count <= overflow_count + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // A halting match stops the run even when its record was lost to overflow.
    always_comb begin
        next_state = state;
        halted     = 1'b0;
        case (state)
            RUN: begin
                if (accept && bp_halt[win_idx]) next_state = HALTED;
            end
            HALTED: begin
                halted = 1'b1;
                if (resume) next_state = RUN;
            end
            default: next_state = RUN;
        endcase
    end

    always_comb begin
        push_rec             = '0;
        push_rec.instance_id = trace_instance_id;
        push_rec.stmt_id     = trace_stmt_id;
        push_rec.bp_idx      = MAX_IDX_W'(win_idx);
        push_rec.timestamp   = MAX_TS_W'(ts_count);
    end

    bp_hit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (hit_rec_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (accept),
        .wr_data (push_rec),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign hit_valid        = !fifo_empty;
    assign hit_instance_id  = head.instance_id;
    assign hit_stmt_id      = head.stmt_id;
    assign hit_bp_idx       = head.bp_idx[IDX_W-1:0];
    assign hit_timestamp    = head.timestamp[TS_WIDTH-1:0];
    assign unused_head_bits = ^head;

endmodule

// File: tb/tb_bp_trace_collector.sv
// Self-checking bench: directed vector table, hand-written corner sequences, then random traffic vs a queue model.
module tb_bp_trace_collector;

    localparam int NUM_BP = 4;
    localparam int DEPTH  = 8;
    localparam int TS_W   = 8;
    localparam logic [31:0] WILD = 32'hFFFFFFFF;

    logic            clk;
    logic            rst_n;
    logic            trace_valid;
    logic [31:0]     trace_instance_id;
    logic [31:0]     trace_stmt_id;
    logic            cfg_we;
    logic [1:0]      cfg_idx;
    logic            cfg_en;
    logic            cfg_halt;
    logic [31:0]     cfg_instance_id;
    logic [31:0]     cfg_stmt_id;
    logic            hit_valid;
    logic            hit_ready;
    logic [31:0]     hit_instance_id;
    logic [31:0]     hit_stmt_id;
    logic [1:0]      hit_bp_idx;
    logic [TS_W-1:0] hit_timestamp;
    logic            resume;
    logic            halted;
    logic [15:0]     overflow_count;

    int checks = 0;
    int errors = 0;

    bp_trace_collector #(
        .NUM_BP     (NUM_BP),
        .FIFO_DEPTH (DEPTH),
        .TS_WIDTH   (TS_W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .trace_valid       (trace_valid),
        .trace_instance_id (trace_instance_id),
        .trace_stmt_id     (trace_stmt_id),
        .cfg_we            (cfg_we),
        .cfg_idx           (cfg_idx),
        .cfg_en            (cfg_en),
        .cfg_halt          (cfg_halt),
        .cfg_instance_id   (cfg_instance_id),
        .cfg_stmt_id       (cfg_stmt_id),
        .hit_valid         (hit_valid),
        .hit_ready         (hit_ready),
        .hit_instance_id   (hit_instance_id),
        .hit_stmt_id       (hit_stmt_id),
        .hit_bp_idx        (hit_bp_idx),
        .hit_timestamp     (hit_timestamp),
        .resume            (resume),
        .halted            (halted),
        .overflow_count    (overflow_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of records plus the table, halt flag, drop counter and timestamp.
    typedef struct {
        logic [31:0] inst;
        logic [31:0] stmt;
        int          idx;
        int          ts;
    } rec_t;

    rec_t        q[$];
    logic [31:0] m_inst [NUM_BP];
    logic [31:0] m_stmt [NUM_BP];
    bit          m_en   [NUM_BP];
    bit          m_halt [NUM_BP];
    bit          m_halted;
    int          m_ovf;
    int          m_ts;

    typedef struct {
        bit          we;
        int          widx;
        bit          wen;
        bit          whalt;
        logic [31:0] winst;
        logic [31:0] wstmt;
        bit          tv;
        logic [31:0] tinst;
        logic [31:0] tstmt;
        bit          rdy;
        bit          res;
        bit          ev;
        logic [31:0] einst;
        logic [31:0] estmt;
        int          eidx;
        int          ets;
        bit          ehalt;
    } row_t;

    row_t rows[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < NUM_BP; i++) begin
            m_inst[i] = '0;
            m_stmt[i] = '0;
            m_en[i]   = 0;
            m_halt[i] = 0;
        end
        m_halted = 0;
        m_ovf    = 0;
        m_ts     = 0;
    endtask

    task automatic model_step();
        bit   do_pop;
        bit   was_full;
        bit   new_halted;
        int   w;
        rec_t r;
        do_pop     = (q.size() > 0) && hit_ready;
        was_full   = (q.size() == DEPTH);
        new_halted = m_halted;
        if (do_pop) void'(q.pop_front());
        if (m_halted) begin
            if (resume) new_halted = 0;
        end else if (trace_valid) begin
            w = -1;
            for (int i = 0; i < NUM_BP; i++)
                if (w < 0 && m_en[i] && m_inst[i] == trace_instance_id &&
                    (m_stmt[i] == WILD || m_stmt[i] == trace_stmt_id)) w = i;
            if (w >= 0) begin
                if (!was_full || do_pop) begin
                    r.inst = trace_instance_id;
                    r.stmt = trace_stmt_id;
                    r.idx  = w;
                    r.ts   = m_ts;
                    q.push_back(r);
                end else if (m_ovf < 65535) begin
                    m_ovf++;
                end
                if (m_halt[w]) new_halted = 1;
            end
        end
        if (cfg_we) begin
            m_en[cfg_idx]   = cfg_en;
            m_halt[cfg_idx] = cfg_halt;
            m_inst[cfg_idx] = cfg_instance_id;
            m_stmt[cfg_idx] = cfg_stmt_id;
        end
        m_halted = new_halted;
        m_ts     = (m_ts + 1) % (1 << TS_W);
    endtask

    task automatic check_output();
        check("model_valid", hit_valid, q.size() > 0);
        if (q.size() > 0)
            check("model_record", {hit_instance_id, hit_stmt_id, hit_bp_idx, hit_timestamp},
                  {q[0].inst, q[0].stmt, 2'(q[0].idx), TS_W'(q[0].ts)});
        check("model_halted", halted, m_halted);
        check("model_overflow", overflow_count, 16'(m_ovf));
    endtask

    task automatic apply_stimulus();
        model_step();
        @(posedge clk);
        #1;
        check_output();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        trace_valid = 0; trace_instance_id = '0; trace_stmt_id = '0;
        cfg_we = 0; cfg_idx = '0; cfg_en = 0; cfg_halt = 0;
        cfg_instance_id = '0; cfg_stmt_id = '0;
        hit_ready = 0; resume = 0;
    endtask

    task automatic set_event(input logic [31:0] inst, input logic [31:0] stmt, input bit rdy);
        clear_inputs();
        trace_valid = 1; trace_instance_id = inst; trace_stmt_id = stmt; hit_ready = rdy;
    endtask

    task automatic set_cfg(input int idx, input logic [31:0] inst, input logic [31:0] stmt,
                           input bit en, input bit hlt, input bit rdy);
        clear_inputs();
        cfg_we = 1; cfg_idx = 2'(idx); cfg_instance_id = inst; cfg_stmt_id = stmt;
        cfg_en = en; cfg_halt = hlt; hit_ready = rdy;
    endtask

    function automatic row_t mk(bit we, int widx, bit wen, bit whalt, logic [31:0] winst, logic [31:0] wstmt,
                                bit tv, logic [31:0] tinst, logic [31:0] tstmt, bit rdy, bit res,
                                bit ev, logic [31:0] einst, logic [31:0] estmt, int eidx, int ets, bit ehalt);
        row_t r;
        r = '{we, widx, wen, whalt, winst, wstmt, tv, tinst, tstmt, rdy, res, ev, einst, estmt, eidx, ets, ehalt};
        return r;
    endfunction

    // Row k is applied in the cycle whose timestamp is k (counted from reset release).
    task automatic fill_rows();
        rows.push_back(mk(1,0,1,0, 2,5,    0,0,0, 1,0, 0,0,0,0,0, 0));
        rows.push_back(mk(1,1,1,0, 0,WILD, 0,0,0, 1,0, 0,0,0,0,0, 0));
        rows.push_back(mk(1,3,1,0, 0,8,    0,0,0, 1,0, 0,0,0,0,0, 0));
        for (int k = 3; k < 10; k++)
            rows.push_back(mk(0,0,0,0, 0,0, 0,0,0, 1,0, 0,0,0,0,0, 0));
        rows.push_back(mk(0,0,0,0, 0,0,    1,2,5, 0,0, 1,2,5,0,10, 0));
        rows.push_back(mk(0,0,0,0, 0,0,    0,0,0, 1,0, 0,0,0,0,0, 0));
        rows.push_back(mk(0,0,0,0, 0,0,    1,0,8, 0,0, 1,0,8,1,12, 0));
        rows.push_back(mk(0,0,0,0, 0,0,    1,0,9, 1,0, 1,0,9,1,13, 0));
        rows.push_back(mk(0,0,0,0, 0,0,    1,1,8, 1,0, 0,0,0,0,0, 0));
        rows.push_back(mk(1,0,0,0, 2,5,    1,2,5, 0,0, 1,2,5,0,15, 0));
        rows.push_back(mk(0,0,0,0, 0,0,    1,2,5, 1,0, 0,0,0,0,0, 0));
        rows.push_back(mk(1,2,1,1, 7,7,    0,0,0, 1,0, 0,0,0,0,0, 0));
        rows.push_back(mk(0,0,0,0, 0,0,    1,7,7, 0,0, 1,7,7,2,18, 1));
        rows.push_back(mk(0,0,0,0, 0,0,    1,7,7, 1,0, 0,0,0,0,0, 1));
        rows.push_back(mk(0,0,0,0, 0,0,    1,7,7, 1,0, 0,0,0,0,0, 1));
        rows.push_back(mk(0,0,0,0, 0,0,    1,7,7, 1,0, 0,0,0,0,0, 1));
        rows.push_back(mk(0,0,0,0, 0,0,    0,0,0, 1,1, 0,0,0,0,0, 0));
        rows.push_back(mk(0,0,0,0, 0,0,    1,7,7, 0,0, 1,7,7,2,23, 1));
        rows.push_back(mk(0,0,0,0, 0,0,    1,7,7, 0,1, 1,7,7,2,23, 0));
        rows.push_back(mk(0,0,0,0, 0,0,    0,0,0, 1,0, 0,0,0,0,0, 0));
        rows.push_back(mk(0,0,0,0, 0,0,    0,0,0, 1,1, 0,0,0,0,0, 0));
    endtask

    initial begin
        int   t0;
        int   drained;
        row_t r;

        clear_inputs();
        rst_n = 0;
        model_reset();
        #1;
        check("reset_valid", hit_valid, 1'b0);
        check("reset_halted", halted, 1'b0);
        check("reset_overflow", overflow_count, 16'd0);
        check("reset_data", {hit_instance_id, hit_stmt_id, hit_bp_idx, hit_timestamp}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        fill_rows();
        for (int k = 0; k < rows.size(); k++) begin
            r = rows[k];
            clear_inputs();
            cfg_we = r.we; cfg_idx = 2'(r.widx); cfg_en = r.wen; cfg_halt = r.whalt;
            cfg_instance_id = r.winst; cfg_stmt_id = r.wstmt;
            trace_valid = r.tv; trace_instance_id = r.tinst; trace_stmt_id = r.tstmt;
            hit_ready = r.rdy; resume = r.res;
            apply_stimulus();
            check($sformatf("row%0d_valid", k), hit_valid, r.ev);
            if (r.ev)
                check($sformatf("row%0d_record", k), {hit_instance_id, hit_stmt_id, hit_bp_idx, hit_timestamp},
                      {r.einst, r.estmt, 2'(r.eidx), TS_W'(r.ets)});
            check($sformatf("row%0d_halted", k), halted, r.ehalt);
        end

        // Ten matches with the consumer stalled: eight kept, two dropped, head frozen.
        set_cfg(0, 2, 5, 1, 0, 0);
        apply_stimulus();
        t0 = m_ts;
        for (int i = 0; i < 10; i++) begin
            set_event(2, 5, 0);
            apply_stimulus();
            check("stall_head", {hit_instance_id, hit_stmt_id, hit_bp_idx, hit_timestamp},
                  {32'd2, 32'd5, 2'd0, TS_W'(t0)});
        end
        check("stall_overflow", overflow_count, 16'd2);

        // Full FIFO with simultaneous push and pop: accepted, no drop.
        set_event(2, 5, 1);
        apply_stimulus();
        check("fullpp_overflow", overflow_count, 16'd2);
        check("fullpp_head_ts", hit_timestamp, TS_W'(t0 + 1));
        clear_inputs();
        hit_ready = 1;
        drained = 0;
        for (int i = 0; i < 20 && hit_valid; i++) begin
            drained++;
            apply_stimulus();
        end
        check("fullpp_count", drained, 8);

        // Queue five records ending in a halting match, then reset asynchronously.
        for (int i = 0; i < 4; i++) begin
            set_event(2, 5, 0);
            apply_stimulus();
        end
        set_event(7, 7, 0);
        apply_stimulus();
        check("prereset_halted", halted, 1'b1);
        check("prereset_depth", q.size(), 5);
        #2 rst_n = 0;
        #1;
        check("async_valid", hit_valid, 1'b0);
        check("async_halted", halted, 1'b0);
        check("async_overflow", overflow_count, 16'd0);
        check("async_data", {hit_instance_id, hit_stmt_id, hit_bp_idx, hit_timestamp}, '0);
        model_reset();
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1;
        set_event(2, 5, 0);
        apply_stimulus();
        check("postreset_nohit", hit_valid, 1'b0);
        set_event(7, 7, 0);
        apply_stimulus();
        check("postreset_nohalt", halted, 1'b0);

        // Random traffic against the model; ready bias varies to exercise overflow and draining.
        for (int blk = 0; blk < 8; blk++) begin
            int rdy_pct;
            rdy_pct = (blk % 2 == 0) ? 15 : 80;
            for (int c = 0; c < 200; c++) begin
                clear_inputs();
                if ($urandom_range(0, 3) == 0) begin
                    cfg_we          = 1;
                    cfg_idx         = 2'($urandom_range(0, 3));
                    cfg_en          = ($urandom_range(0, 3) != 0);
                    cfg_halt        = ($urandom_range(0, 7) == 0);
                    cfg_instance_id = 32'($urandom_range(0, 3));
                    cfg_stmt_id     = ($urandom_range(0, 3) == 0) ? WILD : 32'($urandom_range(0, 3));
                end
                trace_valid       = $urandom_range(0, 1);
                trace_instance_id = 32'($urandom_range(0, 3));
                trace_stmt_id     = 32'($urandom_range(0, 3));
                hit_ready         = ($urandom_range(0, 99) < rdy_pct);
                resume            = ($urandom_range(0, 9) == 0);
                apply_stimulus();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
